// File: rtl/clk_div_ctrl.sv
// Free-running clock divider plus glitch-free CPU clock generator (FAST/SLOW/PROG/STEP).
// Define CLK_DIV_CYCCNT_EN to build the cpu_cycles rising-edge counter and its cyc_clr input.
module clk_div_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SLOW_TAP   = 26,
    parameter int DEB_CYCLES = 16,
    parameter int STEP_HIGH  = 4,
    parameter int TAP_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [TAP_W-1:0] tap_sel,
    input  logic             step_btn,
    input  logic             cyc_clr,
    output logic [WIDTH-1:0] clkdiv,
    output logic             Clk_CPU,
    output logic [1:0]       mode_active,
    output logic             switching,
    output logic [31:0]      cpu_cycles
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int STEP_W = $clog2(STEP_HIGH + 1);

    localparam logic [1:0] M_FAST = 2'b00;
    localparam logic [1:0] M_SLOW = 2'b01;
    localparam logic [1:0] M_PROG = 2'b10;
    localparam logic [1:0] M_STEP = 2'b11;

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_WAIT_LOW = 2'b01,
        S_ALIGN    = 2'b10
    } state_e;

    function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] t);
        if (int'(t) >= WIDTH) begin
            return TAP_W'(WIDTH - 1);
        end
        return t;
    endfunction

    logic [WIDTH-1:0]  clkdiv_q;
    logic              sync1_q, sync2_q;
    logic              deb_lvl_q;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic              deb_accept;
    logic              deb_rise;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic              step_load;
    state_e            state_q, state_d;
    logic [1:0]        mode_active_q, mode_active_d;
    logic [TAP_W-1:0]  tap_lat_q, tap_lat_d;
    logic [TAP_W-1:0]  tap_req;
    logic              change_req;
    logic              clk_cpu_q, clk_cpu_d;
    logic              src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_q <= '0;
        end else begin
            clkdiv_q <= clkdiv_q + WIDTH'(1);
        end
    end

    // Two-flop synchroniser, then a level is accepted once DEB_CYCLES samples in a row differ from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_lvl_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
            if (sync2_q == deb_lvl_q) begin
                deb_cnt_q <= '0;
            end else if (deb_accept) begin
                deb_lvl_q <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign deb_accept = (sync2_q != deb_lvl_q) && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
    assign deb_rise   = deb_accept && sync2_q;

    // A new step is refused while a pulse is counting or its last high cycle is still on Clk_CPU.
    always_comb begin
        step_load = deb_rise && (state_q == S_RUN) && (mode_active_q == M_STEP) &&
                    (step_cnt_q == '0) && !clk_cpu_q;
        step_cnt_d = step_cnt_q;
        if (step_load) begin
            step_cnt_d = STEP_W'(STEP_HIGH);
        end else if (step_cnt_q != '0) begin
            step_cnt_d = step_cnt_q - STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    always_comb begin
        case (mode_active_q)
            M_FAST:  src = ~clk_cpu_q;
            M_SLOW:  src = clkdiv_q[SLOW_TAP];
            M_PROG:  src = clkdiv_q[tap_lat_q];
            default: src = (step_cnt_q != '0);
        endcase
    end

    assign tap_req    = clamp_tap(tap_sel);
    assign change_req = (mode != mode_active_q) || ((mode == M_PROG) && (tap_req != tap_lat_q));

    always_comb begin
        state_d       = state_q;
        mode_active_d = mode_active_q;
        tap_lat_d     = tap_lat_q;
        clk_cpu_d     = src;
        case (state_q)
            S_RUN: begin
                if (change_req) begin
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                // A high phase in flight keeps following the old source until it ends naturally.
                if (!clk_cpu_q) begin
                    clk_cpu_d     = 1'b0;
                    mode_active_d = mode;
                    tap_lat_d     = tap_req;
                    state_d       = (mode == M_STEP) ? S_RUN : S_ALIGN;
                end
            end
            S_ALIGN: begin
                clk_cpu_d = 1'b0;
                if ((mode_active_q == M_FAST) || !src) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            mode_active_q <= M_FAST;
            tap_lat_q     <= '0;
            clk_cpu_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_active_q <= mode_active_d;
            tap_lat_q     <= tap_lat_d;
            clk_cpu_q     <= clk_cpu_d;
        end
    end

`ifdef CLK_DIV_CYCCNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else if (cyc_clr) begin
            cyc_q <= '0;
        end else if (clk_cpu_d && !clk_cpu_q) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cpu_cycles = cyc_q;
`else
    logic unused_cyc_clr;
    assign unused_cyc_clr = cyc_clr;
    assign cpu_cycles     = '0;
`endif

    assign clkdiv      = clkdiv_q;
    assign Clk_CPU     = clk_cpu_q;
    assign mode_active = mode_active_q;
    assign switching   = (state_q != S_RUN);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl (WIDTH=8, SLOW_TAP=4, DEB_CYCLES=4, STEP_HIGH=2).
// Expected Clk_CPU pulses are queued by the stimulus and checked by a monitor as each high phase ends.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  tap_sel = 3'd0;
    logic        step_btn = 1'b0;
    logic        cyc_clr = 1'b0;
    logic [7:0]  clkdiv;
    logic        Clk_CPU;
    logic [1:0]  mode_active;
    logic        switching;
    logic [31:0] cpu_cycles;

    clk_div_ctrl #(
        .WIDTH(8), .SLOW_TAP(4), .DEB_CYCLES(4), .STEP_HIGH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .tap_sel(tap_sel),
        .step_btn(step_btn), .cyc_clr(cyc_clr), .clkdiv(clkdiv),
        .Clk_CPU(Clk_CPU), .mode_active(mode_active), .switching(switching),
        .cpu_cycles(cpu_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int hi;
        int lo;
    } pulse_t;

    pulse_t exp_q[$];
    bit     mon_en = 1'b0;
    bit     strict = 1'b0;
    int     n_pulses = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures every Clk_CPU high/low phase; an armed pulse is compared on its falling edge.
    bit prev = 1'b0;
    bit armed = 1'b0;
    int hi_len = 0, lo_len = 0, last_lo = 0;
    always @(negedge clk) begin
        pulse_t e;
        if (!rst_n) begin
            prev = 1'b0; armed = 1'b0; hi_len = 0; lo_len = 0;
        end else if (Clk_CPU) begin
            if (!prev) begin
                last_lo = lo_len; hi_len = 1; armed = mon_en;
            end else begin
                hi_len++;
            end
            prev = 1'b1;
        end else begin
            if (prev) begin
                n_pulses++;
                if (armed) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pulse_high_len", hi_len, e.hi);
                        if (e.lo >= 0) check("pulse_low_len", last_lo, e.lo);
                    end else if (strict) begin
                        check("unexpected_pulse_len", hi_len, 0);
                    end
                end
                lo_len = 1;
            end else begin
                lo_len++;
            end
            prev = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_settled(input int m, input int budget);
        int i = 0;
        while (((mode_active !== 2'(m)) || switching) && i < budget) begin
            tick();
            i++;
        end
        check("settle_mode", mode_active, m);
        check("settle_switching", switching, 0);
    endtask

    task automatic wait_clk_low(input int budget);
        int i = 0;
        while (Clk_CPU && i < budget) begin
            tick();
            i++;
        end
        check("clk_low_wait", Clk_CPU, 0);
    endtask

    task automatic push_pulse(input int hi, input int lo);
        pulse_t p;
        p.hi = hi;
        p.lo = lo;
        exp_q.push_back(p);
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check("pulses_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic expect_run(input int n, input int hi, input int lo, input int budget);
        wait_clk_low(budget);
        for (int k = 0; k < n; k++) push_pulse(hi, (k == 0) ? -1 : lo);
        mon_en = 1'b1;
        drain(budget);
        mon_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clkdiv"}, clkdiv, 0);
        check({tag, "_clk_cpu"}, Clk_CPU, 0);
        check({tag, "_mode_active"}, mode_active, 0);
        check({tag, "_switching"}, switching, 0);
        check({tag, "_cpu_cycles"}, cpu_cycles, 0);
    endtask

    initial begin
        int i;
        int base;
        logic [7:0] prv;

        // Reset, count, mid-count reset and wrap
        tick(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick(10);
        check("count_after_release", clkdiv, 10);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick(3);
        check("clk_cpu_in_reset", Clk_CPU, 0);
        rst_n = 1'b1;
        check("count_start", clkdiv, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("count_seq", clkdiv, k);
        end
        i = 0;
        while (clkdiv != 8'd255 && i < 300) begin tick(); i++; end
        check("count_max", clkdiv, 255);
        tick();
        check("count_wrap", clkdiv, 0);

        // FAST mode and cycle counter
        expect_run(5, 1, 1, 40);
`ifdef CLK_DIV_CYCCNT_EN
        wait_clk_low(4);
        cyc_clr = 1'b1;
        tick();
        cyc_clr = 1'b0;
        check("cyc_clr_on_edge", cpu_cycles, 0);
        check("cyc_clr_edge_clk", Clk_CPU, 1);
        tick(20);
        check("cyc_count_10", cpu_cycles, 10);
`else
        cyc_clr = 1'b1;
        tick();
        cyc_clr = 1'b0;
        tick(20);
        check("cyc_tied_zero", cpu_cycles, 0);
`endif

        // SLOW mode
        mode = 2'b01;
        tick();
        check("slow_switching", switching, 1);
        wait_settled(1, 100);
        expect_run(3, 16, 16, 200);
        for (int k = 0; k < 32; k++) begin
            tick();
            prv = clkdiv - 8'd1;
            check("slow_follow", Clk_CPU, prv[4]);
        end

        // PROG mode: tap 2, top tap, tap change during a high phase
        tap_sel = 3'd2;
        mode = 2'b10;
        tick();
        wait_settled(2, 100);
        expect_run(3, 4, 4, 100);
        tap_sel = 3'd7;
        tick();
        wait_settled(2, 300);
        expect_run(2, 128, 128, 700);
        tap_sel = 3'd2;
        tick();
        wait_settled(2, 300);
        wait_clk_low(20);
        push_pulse(4, -1);
        mon_en = 1'b1;
        i = 0;
        while (!Clk_CPU && i < 20) begin tick(); i++; end
        check("prog_rise_seen", Clk_CPU, 1);
        tap_sel = 3'd3;
        push_pulse(8, -1);
        push_pulse(8, 8);
        tick();
        check("prog_tap_switching", switching, 1);
        check("prog_high_kept", Clk_CPU, 1);
        drain(150);
        mon_en = 1'b0;
        check("prog_tap_latched_mode", mode_active, 2);

        // STEP mode
        mode = 2'b00;
        tick();
        wait_settled(0, 300);
        step_btn = 1'b1;
        tick(10);
        mode = 2'b11;
        tick();
        wait_settled(3, 20);
        wait_clk_low(4);
        mon_en = 1'b1;
        strict = 1'b1;
        base = n_pulses;
        tick(20);
        check("no_queued_step", n_pulses - base, 0);
        step_btn = 1'b0;
        tick(10);
        push_pulse(2, -1);
        step_btn = 1'b1; tick(2);
        step_btn = 1'b0; tick(2);
        step_btn = 1'b1; tick(6);
        drain(30);
        step_btn = 1'b0; tick(2);
        step_btn = 1'b1; tick(20);
        check("step_single_pulse", n_pulses - base, 1);
        step_btn = 1'b0;
        tick(10);
        push_pulse(2, -1);
        step_btn = 1'b1;
        drain(30);
        tick(5);
        check("step_second_pulse", n_pulses - base, 2);
        strict = 1'b0;
        mon_en = 1'b0;
        step_btn = 1'b0;
        tick(10);

        // Reset during WAIT_LOW
        mode = 2'b01;
        tick();
        wait_settled(1, 100);
        i = 0;
        while (!Clk_CPU && i < 40) begin tick(); i++; end
        mode = 2'b00;
        tick();
        check("waitlow_switching", switching, 1);
        check("waitlow_high_kept", Clk_CPU, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_waitlow");
        tick(2);
        rst_n = 1'b1;

        // Reset during ALIGN
        i = 0;
        while (clkdiv != 8'd16 && i < 300) begin tick(); i++; end
        mode = 2'b01;
        i = 0;
        while (!(switching && mode_active == 2'b01) && i < 10) begin tick(); i++; end
        check("align_mode_latched", mode_active, 1);
        check("align_switching", switching, 1);
        check("align_clk_held", Clk_CPU, 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_align");
        tick(2);
        rst_n = 1'b1;

        // Reset mid-step
        mode = 2'b11;
        tick();
        wait_settled(3, 20);
        step_btn = 1'b1;
        i = 0;
        while (!Clk_CPU && i < 30) begin tick(); i++; end
        check("midstep_pulse_seen", Clk_CPU, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_midstep");
        tick(2);
        rst_n = 1'b1;
        step_btn = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
